// File: rtl/mmio_pkg.sv
// Shared definitions for the MEM-stage memory-mapped I/O port:
// register offsets within the 16-byte window, STATUS bit positions,
// the default window base and the window decode helper.
package mmio_pkg;

  // Default base of the 16-byte I/O window (only bits [31:4] matter)
  localparam logic [31:0] DEFAULT_IO_BASE = 32'h1000_0000;

  // Register select values taken from Address[3:2]
  localparam logic [1:0] REG_PORT_OUT = 2'd0;
  localparam logic [1:0] REG_PORT_IN  = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_TIMER    = 2'd3;

  // STATUS register bit positions
  localparam int ST_IN_CHANGED  = 0;
  localparam int ST_TMR_EXPIRED = 1;

  // True when addr falls inside the 16-byte window starting at base
  function automatic logic isIoAddr(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/mem_stage_mmio_port_sync.sv
// Input-port synchronizer: STAGES flops on the asynchronous input,
// followed by a one-flop history register. The change output is high
// whenever the synchronized value differs from the history register.
module port_in_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut,
  output logic             changed
);

  logic [WIDTH-1:0] syncChain [STAGES];
  logic [WIDTH-1:0] history;

  // Shift the input through the synchronizer chain and remember the last value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) syncChain[i] <= '0;
      history <= '0;
    end else begin
      syncChain[0] <= asyncIn;
      for (int i = 1; i < STAGES; i++) syncChain[i] <= syncChain[i-1];
      history <= syncChain[STAGES-1];
    end
  end

  assign syncOut = syncChain[STAGES-1];
  assign changed = (syncChain[STAGES-1] != history);

endmodule

// File: rtl/mem_stage_mmio_port.sv
// MEM-stage memory-mapped I/O port, sitting beside the data RAM.
// Decodes a 16-byte window at IO_BASE holding PORT_OUT, PORT_IN, STATUS
// and a down-counting TIMER, gates RAM stores away from that window and
// muxes I/O read data in front of RAM read data combinationally.
// Optional macro MMIO_IRQ_EN adds a writable interrupt mask in STATUS
// and a registered Irq output.
module mem_stage_mmio_port
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE       = DEFAULT_IO_BASE,
  parameter int          PORT_IN_WIDTH = 8,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              Address,
  input  logic [31:0]              WriteData,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [31:0]              RamReadData,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic                     RamMemWrite,
  output logic [31:0]              ReadData,
`ifdef MMIO_IRQ_EN
  output logic                     Irq,
`endif
  output logic [31:0]              PortOut
);

  logic                     isIo;
  logic [1:0]               regSel;
  logic                     ioWrite;
  logic                     statusRead;
  logic                     timerWrite;
  logic                     unusedAddrBits;

  logic [PORT_IN_WIDTH-1:0] portInSync;
  logic                     inChangeEvt;

  logic [31:0]              portOutReg;
  logic [31:0]              timerCount;
  logic [31:0]              ioRdata;
  logic                     tmrHitZero;
  logic                     inChanged;
  logic                     tmrExpired;
  logic                     inChangedNext;
  logic                     tmrExpiredNext;

`ifdef MMIO_IRQ_EN
  logic [1:0]               irqMask;
  logic                     irqReg;
`endif

  // Byte offset within a word has no meaning for these registers
  assign unusedAddrBits = ^Address[1:0];

  assign isIo       = isIoAddr(Address, IO_BASE);
  assign regSel     = Address[3:2];
  assign ioWrite    = MemWrite & isIo;
  assign statusRead = MemRead & isIo & (regSel == REG_STATUS);
  assign timerWrite = ioWrite & (regSel == REG_TIMER);

  // A store into the window never reaches the RAM
  assign RamMemWrite = MemWrite & ~isIo;
  assign ReadData    = isIo ? ioRdata : RamReadData;
  assign PortOut     = portOutReg;

  port_in_sync #(
    .WIDTH  (PORT_IN_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .asyncIn (PortIn),
    .syncOut (portInSync),
    .changed (inChangeEvt)
  );

  // Register read mux; STATUS shows flag values before any clear-on-read
  always_comb begin
    ioRdata = '0;
    case (regSel)
      REG_PORT_OUT: ioRdata = portOutReg;
      REG_PORT_IN:  ioRdata = 32'(portInSync);
      REG_STATUS: begin
        ioRdata[ST_IN_CHANGED]  = inChanged;
        ioRdata[ST_TMR_EXPIRED] = tmrExpired;
`ifdef MMIO_IRQ_EN
        ioRdata[3:2]            = irqMask;
`endif
      end
      REG_TIMER:    ioRdata = timerCount;
      default:      ioRdata = '0;
    endcase
  end

  // Output port register, loaded by stores to PORT_OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      portOutReg <= '0;
    end else if (ioWrite && (regSel == REG_PORT_OUT)) begin
      portOutReg <= WriteData;
    end
  end

  // The natural 1->0 step expires the timer; a load that cycle pre-empts it
  assign tmrHitZero = (timerCount == 32'd1) & ~timerWrite;

  // Down counter: a store loads it, otherwise it counts toward zero and halts
  always_ff @(posedge clk) begin
    if (reset) begin
      timerCount <= '0;
    end else if (timerWrite) begin
      timerCount <= WriteData;
    end else if (timerCount != 32'd0) begin
      timerCount <= timerCount - 32'd1;
    end
  end

  // Sticky flags: clear-on-read first, then a same-cycle set event wins
  always_comb begin
    inChangedNext  = inChanged;
    tmrExpiredNext = tmrExpired;
    if (statusRead) begin
      inChangedNext  = 1'b0;
      tmrExpiredNext = 1'b0;
    end
    if (inChangeEvt) inChangedNext  = 1'b1;
    if (tmrHitZero)  tmrExpiredNext = 1'b1;
  end

  // Status flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      inChanged  <= 1'b0;
      tmrExpired <= 1'b0;
    end else begin
      inChanged  <= inChangedNext;
      tmrExpired <= tmrExpiredNext;
    end
  end

`ifdef MMIO_IRQ_EN
  // Interrupt enable mask, written through the STATUS address
  always_ff @(posedge clk) begin
    if (reset) begin
      irqMask <= '0;
    end else if (ioWrite && (regSel == REG_STATUS)) begin
      irqMask <= WriteData[1:0];
    end
  end

  // Registered interrupt: follows the enabled flags one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      irqReg <= 1'b0;
    end else begin
      irqReg <= |({tmrExpired, inChanged} & irqMask);
    end
  end

  assign Irq = irqReg;
`endif

endmodule

// File: tb/tb_mem_stage_mmio_port.sv
// Directed self-checking bench for mem_stage_mmio_port.
module tb_mem_stage_mmio_port;

  localparam logic [31:0] IO   = 32'h1000_0000;
  localparam int          SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] RamReadData;
  logic [7:0]  PortIn;
  logic        RamMemWrite;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
`ifdef MMIO_IRQ_EN
  logic        Irq;
`endif

  int nAssert = 0;
  int nFail   = 0;

  mem_stage_mmio_port #(
    .IO_BASE       (IO),
    .PORT_IN_WIDTH (8),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .RamReadData (RamReadData),
    .PortIn      (PortIn),
    .RamMemWrite (RamMemWrite),
    .ReadData    (ReadData),
`ifdef MMIO_IRQ_EN
    .Irq         (Irq),
`endif
    .PortOut     (PortOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = a;
    WriteData = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0000_0100, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1; PortIn = 8'h00; RamReadData = 32'h0;
    idle();
    tick(); tick();
    reset = 1'b0;
    nAssert++; if (PortOut !== 32'h0) begin nFail++; $display("FAIL rst_portout: got %h expected %h", PortOut, 32'h0); end
    nAssert++; if (RamMemWrite !== 1'b0) begin nFail++; $display("FAIL rst_ramwe: got %b expected 0", RamMemWrite); end
    drive(1'b1, 1'b0, IO + 32'hC, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL rst_timer: got %h expected %h", ReadData, 32'h0); end
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL rst_status: got %h expected %h", ReadData, 32'h0); end
    idle();
  endtask

  task automatic test_port_out();
    drive(1'b0, 1'b1, IO, 32'hDEAD_BEEF);
    nAssert++; if (RamMemWrite !== 1'b0) begin nFail++; $display("FAIL po_ramwe: got %b expected 0", RamMemWrite); end
    tick();
    idle();
    nAssert++; if (PortOut !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL po_value: got %h expected %h", PortOut, 32'hDEAD_BEEF); end
    drive(1'b1, 1'b0, IO + 32'h1, 32'h0);
    nAssert++; if (ReadData !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL po_load: got %h expected %h", ReadData, 32'hDEAD_BEEF); end
    // load and store together: old value is returned, new value lands
    drive(1'b1, 1'b1, IO, 32'h1234_5678);
    nAssert++; if (ReadData !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL po_rw_old: got %h expected %h", ReadData, 32'hDEAD_BEEF); end
    tick();
    idle();
    nAssert++; if (PortOut !== 32'h1234_5678) begin nFail++; $display("FAIL po_rw_new: got %h expected %h", PortOut, 32'h1234_5678); end
    // PORT_IN is read-only
    drive(1'b0, 1'b1, IO + 32'h4, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 1'b0, IO + 32'h4, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL pin_ro: got %h expected %h", ReadData, 32'h0); end
    idle();
  endtask

  task automatic test_ram_path();
    RamReadData = 32'hCAFE_F00D;
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h5);
    nAssert++; if (RamMemWrite !== 1'b1) begin nFail++; $display("FAIL ram_we: got %b expected 1", RamMemWrite); end
    tick();
    idle();
    nAssert++; if (PortOut !== 32'h1234_5678) begin nFail++; $display("FAIL ram_portout: got %h expected %h", PortOut, 32'h1234_5678); end
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    nAssert++; if (ReadData !== 32'hCAFE_F00D) begin nFail++; $display("FAIL ram_rdata: got %h expected %h", ReadData, 32'hCAFE_F00D); end
    drive(1'b0, 1'b1, IO + 32'h10, 32'h7);
    nAssert++; if (RamMemWrite !== 1'b1) begin nFail++; $display("FAIL ram_edge_we: got %b expected 1", RamMemWrite); end
    idle();
    RamReadData = 32'h0;
  endtask

  task automatic test_port_in();
    PortIn = 8'hA5;
    drive(1'b1, 1'b0, IO + 32'h4, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL pin_c0: got %h expected %h", ReadData, 32'h0); end
    for (int i = 1; i < SYNC; i++) begin
      tick();
      nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL pin_early: cycle %0d got %h expected %h", i, ReadData, 32'h0); end
    end
    tick();
    nAssert++; if (ReadData !== 32'h0000_00A5) begin nFail++; $display("FAIL pin_sync: got %h expected %h", ReadData, 32'h0000_00A5); end
    tick();
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h1) begin nFail++; $display("FAIL pin_status: got %h expected %h", ReadData, 32'h1); end
    tick();
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL pin_clear: got %h expected %h", ReadData, 32'h0); end
    idle();
  endtask

  task automatic test_timer();
    logic [31:0] exp;
    drive(1'b0, 1'b1, IO + 32'hC, 32'h3);
    tick();
    drive(1'b1, 1'b0, IO + 32'hC, 32'h0);
    exp = 32'h3;
    for (int i = 0; i < 4; i++) begin
      nAssert++; if (ReadData !== exp) begin nFail++; $display("FAIL tmr_count: step %0d got %h expected %h", i, ReadData, exp); end
      if (i < 3) begin tick(); exp = exp - 32'h1; end
    end
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h2) begin nFail++; $display("FAIL tmr_expired: got %h expected %h", ReadData, 32'h2); end
    tick();
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL tmr_clear: got %h expected %h", ReadData, 32'h0); end
    drive(1'b1, 1'b0, IO + 32'hC, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL tmr_halt: got %h expected %h", ReadData, 32'h0); end
    // stop a countdown by writing 0
    drive(1'b0, 1'b1, IO + 32'hC, 32'h5);
    tick();
    idle();
    tick();
    drive(1'b0, 1'b1, IO + 32'hC, 32'h0);
    tick();
    idle();
    tick(); tick();
    drive(1'b1, 1'b0, IO + 32'hC, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL tmr_stop: got %h expected %h", ReadData, 32'h0); end
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL tmr_stop_status: got %h expected %h", ReadData, 32'h0); end
    idle();
  endtask

  task automatic test_status_race();
    drive(1'b0, 1'b1, IO + 32'hC, 32'h2);
    tick();
    idle();
    tick();
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL race_preclear: got %h expected %h", ReadData, 32'h0); end
    tick();
    nAssert++; if (ReadData !== 32'h2) begin nFail++; $display("FAIL race_setwins: got %h expected %h", ReadData, 32'h2); end
    tick();
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL race_clear: got %h expected %h", ReadData, 32'h0); end
    idle();
  endtask

`ifdef MMIO_IRQ_EN
  task automatic test_irq();
    nAssert++; if (Irq !== 1'b0) begin nFail++; $display("FAIL irq_idle: got %b expected 0", Irq); end
    drive(1'b0, 1'b1, IO + 32'h8, 32'h2);
    tick();
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h8) begin nFail++; $display("FAIL irq_mask: got %h expected %h", ReadData, 32'h8); end
    drive(1'b0, 1'b1, IO + 32'hC, 32'h1);
    tick();
    idle();
    tick();
    nAssert++; if (Irq !== 1'b0) begin nFail++; $display("FAIL irq_lag: got %b expected 0", Irq); end
    tick();
    nAssert++; if (Irq !== 1'b1) begin nFail++; $display("FAIL irq_rise: got %b expected 1", Irq); end
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'hA) begin nFail++; $display("FAIL irq_status: got %h expected %h", ReadData, 32'hA); end
    idle();
  endtask
`else
  task automatic test_status_ro();
    drive(1'b0, 1'b1, IO + 32'h8, 32'h3);
    tick();
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL status_ro: got %h expected %h", ReadData, 32'h0); end
    idle();
  endtask
`endif

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, IO, 32'hFF);
    tick();
    drive(1'b0, 1'b1, IO + 32'hC, 32'd10);
    tick();
    idle();
    tick(); tick();
    nAssert++; if (PortOut !== 32'hFF) begin nFail++; $display("FAIL rm_pre: got %h expected %h", PortOut, 32'hFF); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nAssert++; if (PortOut !== 32'h0) begin nFail++; $display("FAIL rm_portout: got %h expected %h", PortOut, 32'h0); end
`ifdef MMIO_IRQ_EN
    nAssert++; if (Irq !== 1'b0) begin nFail++; $display("FAIL rm_irq: got %b expected 0", Irq); end
`endif
    drive(1'b1, 1'b0, IO + 32'hC, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL rm_timer: got %h expected %h", ReadData, 32'h0); end
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL rm_status: got %h expected %h", ReadData, 32'h0); end
    idle();
    tick(); tick();
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h0) begin nFail++; $display("FAIL rm_noexpiry: got %h expected %h", ReadData, 32'h0); end
    idle();
    tick();
    drive(1'b1, 1'b0, IO + 32'h8, 32'h0);
    nAssert++; if (ReadData !== 32'h1) begin nFail++; $display("FAIL rm_firstin: got %h expected %h", ReadData, 32'h1); end
    idle();
  endtask

  initial begin
    test_reset();
    test_port_out();
    test_ram_path();
    test_port_in();
    test_timer();
    test_status_race();
`ifdef MMIO_IRQ_EN
    test_irq();
`else
    test_status_ro();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/mem_stage_mmio_port.md
Name: mem_stage_mmio_port

Overview:
- Memory-mapped I/O unit in the MEM stage, beside the data RAM.
- Consumes the EX/MEM address, store data and MemRead/MemWrite controls.
- Decodes an I/O window and drives the 32-bit output port. Samples the 8-bit input port through a synchronizer.
- Provides a sticky input-change flag and a down-counting timer. Returns read data combinationally so the MEM/WB register latches it like RAM data.

Parameters:
- IO_BASE, 32'h1000_0000, base of a 16-byte I/O window; only bits [31:4] are compared.
- PORT_IN_WIDTH, 8, width of the external input port.
- SYNC_STAGES, 2, flip-flop stages on PortIn; legal range 2-3.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- Address  input  32  EX/MEM ALU result
- WriteData  input  32  EX/MEM store data (rt)
- MemWrite  input  1  EX/MEM store strobe
- MemRead  input  1  EX/MEM load strobe
- RamReadData  input  32  data RAM read output
- PortIn  input  PORT_IN_WIDTH  asynchronous external input
- RamMemWrite  output  1  MemWrite gated off for I/O addresses; drives the RAM
- ReadData  output  32  RAM/IO-muxed load data to MEM/WB
- PortOut  output  32  registered output port

Behaviour:
- Decode: is_io = (Address[31:4] == IO_BASE[31:4]). Register select = Address[3:2]. Address[1:0] is ignored.
- RamMemWrite = MemWrite & ~is_io. ReadData = is_io ? io_rdata : RamReadData. Both paths are purely combinational.
- Register map:
  - 0x0 PORT_OUT: read/write, 32 bits.
  - 0x4 PORT_IN: read-only; synchronized value, zero-extended.
  - 0x8 STATUS: read-only. bit0 = in_changed, bit1 = tmr_expired; other bits read 0. Clear-on-read.
  - 0xC TIMER: read/write; reads the current count.
- Writes take effect at the clock edge when MemWrite & is_io. Writes to PORT_IN and STATUS are ignored.
- PORT_OUT: the value written is visible on PortOut the cycle after the edge.
- Synchronizer: SYNC_STAGES flops, then a one-flop history register. A difference between the last stage and the history register sets in_changed at the next edge. Minimum latency from a PortIn change to the PORT_IN read value is SYNC_STAGES cycles.
- Timer: a 32-bit down counter.
  - When nonzero, it decrements by 1 each cycle.
  - The transition 1->0 sets tmr_expired.
  - Writing loads the counter and overrides the decrement that cycle.
  - Writing 0 stops the counter without setting tmr_expired.
- STATUS clear-on-read: when MemRead & is_io & select==2, the bits that were read are cleared at that edge.
  - A set event in the same cycle wins: the flag stays 1 and will read 1 next time.
  - ReadData in the clearing cycle shows the pre-clear value.
- MemRead and MemWrite both high: the write is applied, ReadData shows the old register value, and clear-on-read still applies.
- Non-I/O accesses have no side effects on this block.
- Reset (synchronous, wins over everything):
  - PortOut=0, timer=0, in_changed=0, tmr_expired=0, synchronizer and history flops=0.
  - Reset in the middle of a timer countdown discards the countdown without setting expiry.
  - The first non-zero synchronized PortIn after reset sets in_changed.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- When defined:
  - Adds output port `Irq` (1 bit).
  - Address 0x8 becomes read/write. Writes set an irq-enable mask from WriteData[1:0] and do not touch the status flags; the mask resets to 0.
  - STATUS reads return the mask in bits [3:2].
  - Irq = |(status[1:0] & mask), registered, so Irq rises one cycle after the flag sets.
- When undefined: no Irq port, no mask, and STATUS is read-only as described above.

Decomposition:
- Shared package mmio_pkg holds:
  - register offsets REG_PORT_OUT=2'd0, REG_PORT_IN=2'd1, REG_STATUS=2'd2, REG_TIMER=2'd3;
  - status bit indices ST_IN_CHANGED=0 and ST_TMR_EXPIRED=1;
  - the default IO_BASE.
- One natural sub-module, port_in_sync, parameterized by width and stage count. It contains the synchronizer, the history register and the change-pulse output.

Test Plan:
1. Reset, then a store of 32'hDEAD_BEEF to 0x1000_0000: PortOut=32'hDEAD_BEEF next cycle; RamMemWrite=0 throughout; a load from 0x1000_0000 returns 32'hDEAD_BEEF.
2. A store of 32'h5 to 0x0000_0010 (RAM address): RamMemWrite=1; PortOut unchanged; ReadData follows RamReadData.
3. PortIn changes 8'h00->8'hA5 at cycle 0: a PORT_IN read returns 32'h0000_00A5 from cycle SYNC_STAGES; the STATUS read returns bit0=1; the next STATUS read returns 0.
4. Store 3 to TIMER: reads give 2, 1, 0 on following cycles; STATUS bit1=1 after reaching 0. Storing 0 mid-count stops the counter with bit1 staying 0.
5. STATUS read in the same cycle the timer hits 0: ReadData bit1=0 (pre-clear value); the following STATUS read returns bit1=1.
6. Assert reset mid-countdown with PortOut=32'hFF: next cycle PortOut=0, TIMER reads 0, STATUS reads 0. With MMIO_IRQ_EN defined, Irq=0.
